serial_signed_adder: RTL and testbench

//   Bit-serial two's-complement adder/subtractor that produces the result and the

---
 rtl/serial_signed_adder.sv | 124 ++++++++++++
 tb/tb_serial_signed_adder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_signed_adder.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per clock.
// Latency: WIDTH+1 edges from accepted start to the one-cycle done pulse.
// Backpressure: none; start is only sampled in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start, sub      operation request and add(0)/subtract(1) select
//   a, b            signed operands, captured on an accepted start
//   busy, done      high while adding / one-cycle completion pulse
//   sum, overflow   registered result and signed-overflow flag, held until next completion
module serial_signed_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;

  // Full-adder slice working on the current LSBs of the shifting operands.
  logic             sum_bit;
  logic             carry_out;
  logic [WIDTH-1:0] res_next;

  assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign carry_out = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  assign res_next  = {sum_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADD: begin
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        res_d   = res_next;
        carry_d = carry_out;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // MSB slice: overflow when both operand signs agree and the result sign differs.
          // The carry out of the MSB is simply dropped.
          sum_d   = res_next;
          ovf_d   = (opa_q[0] == opb_q[0]) && (opa_q[0] != sum_bit);
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == S_ADD);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_signed_adder.sv
// Testbench for serial_signed_adder (WIDTH=8): directed corner cases, back-to-back
// starts, mid-operation reset and randomised operations against an arithmetic model.
module tb_serial_signed_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  serial_signed_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain signed integer arithmetic, {overflow, sum}.
  function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    int r;
    logic [W-1:0] lo;
    if (s) r = int'($signed(x)) - int'($signed(y));
    else   r = int'($signed(x)) + int'($signed(y));
    lo = r[W-1:0];
    return {(r > 127) || (r < -128), lo};
  endfunction

  // Drives one operation from an idle/done DUT and waits for done (lat=-1 on timeout).
  // Operand inputs are scrambled right after acceptance.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [W-1:0] rs, output logic ro, output int lat);
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    rs = sum;
    ro = overflow;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sum !== 8'h00)     begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] rs; logic ro; int lat;
    do_op(8'd5, 8'd3, 1'b0, rs, ro, lat);
    checks++; if (lat != W)      begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, W); end
    checks++; if (rs !== 8'h08)  begin errors++; $display("FAIL basic_sum got %h want 08", rs); end
    checks++; if (ro !== 1'b0)   begin errors++; $display("FAIL basic_ovf got %b want 0", ro); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (sum !== 8'h08) begin errors++; $display("FAIL basic_sum_held got %h want 08", sum); end
  endtask

  task automatic test_corners();
    logic [W-1:0] ta [5] = '{8'd100, 8'h80, 8'h80, 8'h00, 8'd7};
    logic [W-1:0] tb [5] = '{8'd50,  8'hFF, 8'h01, 8'h80, 8'd7};
    logic         ts [5] = '{1'b0,   1'b0,  1'b1,  1'b1,  1'b1};
    logic [W-1:0] es [5] = '{8'h96,  8'h7F, 8'h7F, 8'h80, 8'h00};
    logic         eo [5] = '{1'b1,   1'b1,  1'b1,  1'b1,  1'b0};
    logic [W-1:0] rs; logic ro; int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], ts[i], rs, ro, lat);
      checks++; if (lat != W)     begin errors++; $display("FAIL corner%0d_latency got %0d want %0d", i, lat, W); end
      checks++; if (rs !== es[i]) begin errors++; $display("FAIL corner%0d_sum got %h want %h", i, rs, es[i]); end
      checks++; if (ro !== eo[i]) begin errors++; $display("FAIL corner%0d_ovf got %b want %b", i, ro, eo[i]); end
    end
  endtask

  // start held high continuously: captures happen at edges 1, 10, 19; done after 9, 18, 27.
  task automatic test_back_to_back();
    logic [W-1:0] va [0:40];
    logic [W-1:0] vb [0:40];
    logic         vs [0:40];
    logic [W:0]   exp;
    logic         exp_done;
    int           n_done = 0;
    @(negedge clk);
    start = 1'b1;
    va[1] = W'($urandom); vb[1] = W'($urandom); vs[1] = 1'($urandom);
    a = va[1]; b = vb[1]; sub = vs[1];
    for (int e = 1; e <= 27; e++) begin
      @(negedge clk);
      exp_done = (e % 9) == 0;
      checks++; if (done !== exp_done) begin
        errors++; $display("FAIL b2b_done edge%0d got %b want %b", e, done, exp_done);
      end
      checks++; if (busy !== !exp_done) begin
        errors++; $display("FAIL b2b_busy edge%0d got %b want %b", e, busy, !exp_done);
      end
      if (done) n_done++;
      if (exp_done) begin
        exp = ref_model(va[e-8], vb[e-8], vs[e-8]);
        checks++; if ({overflow, sum} !== exp) begin
          errors++; $display("FAIL b2b_result edge%0d got ovf=%b sum=%h want ovf=%b sum=%h",
                             e, overflow, sum, exp[W], exp[W-1:0]);
        end
      end
      start = (e < 27);
      va[e+1] = W'($urandom); vb[e+1] = W'($urandom); vs[e+1] = 1'($urandom);
      a = va[e+1]; b = vb[e+1]; sub = vs[e+1];
    end
    @(negedge clk);
    checks++; if (n_done != 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", n_done); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_reset_mid_add();
    int n_done = 0;
    @(negedge clk);
    a = 8'd100; b = 8'd27; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);   // bits 0..3 processed
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rst_mid_done got %b want 0", done); end
    checks++; if (sum !== 8'h00)     begin errors++; $display("FAIL rst_mid_sum got %h want 00", sum); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got %b want 0", overflow); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++; if (n_done != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d dones want 0", n_done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rst_mid_sum_after got %h want 00", sum); end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, rs; logic s, ro; int lat;
    logic [W:0] exp;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom); y = W'($urandom); s = 1'($urandom);
      exp = ref_model(x, y, s);
      do_op(x, y, s, rs, ro, lat);
      checks++;
      if (lat != W || rs !== exp[W-1:0] || ro !== exp[W]) begin
        errors++;
        if (bad < 10) $display("FAIL random%0d a=%h b=%h sub=%b got lat=%0d sum=%h ovf=%b want lat=%0d sum=%h ovf=%b",
                               i, x, y, s, lat, rs, ro, W, exp[W-1:0], exp[W]);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid_add();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
